// File: rtl/velocity_cache_array_if.sv
// Motion Update bus for the velocity cache grid: read/write/swap strobes in, per-cell read data out.
interface velocity_cache_array_if #(
  parameter int NUM_CELLS         = 125,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7
);
  logic                                   Motion_Update_enable;
  logic [PARTICLE_ID_WIDTH-1:0]           MU_rd_addr;
  logic                                   MU_rden;
  logic [3*DATA_WIDTH-1:0]                MU_wr_data;
  logic [3*CELL_ID_WIDTH-1:0]             MU_dst_cell;
  logic                                   MU_wr_data_valid;
  logic                                   MU_swap;
  logic [NUM_CELLS-1:0][3*DATA_WIDTH-1:0] velocity_data_out;
  logic                                   velocity_data_valid;

  modport master (
    output Motion_Update_enable, MU_rd_addr, MU_rden, MU_wr_data,
           MU_dst_cell, MU_wr_data_valid, MU_swap,
    input  velocity_data_out, velocity_data_valid
  );

  modport slave (
    input  Motion_Update_enable, MU_rd_addr, MU_rden, MU_wr_data,
           MU_dst_cell, MU_wr_data_valid, MU_swap,
    output velocity_data_out, velocity_data_valid
  );
endinterface

// File: rtl/velocity_cache_array.sv
// 3-D grid of ping-pong velocity caches: every cell reads its active bank, updated
// velocities go to the shadow bank of the destination cell, and a swap flips the banks.
module velocity_cache_array #(
  parameter  int CELLS_X               = 5,
  parameter  int CELLS_Y               = 5,
  parameter  int CELLS_Z               = 5,
  parameter  int DATA_WIDTH            = 32,
  parameter  int CELL_ID_WIDTH         = 3,
  parameter  int NUM_PARTICLE_PER_CELL = 128,
  parameter  int PARTICLE_ID_WIDTH     = 7,
  localparam int NUM_CELLS             = CELLS_X * CELLS_Y * CELLS_Z,
  localparam int CNT_W                 = PARTICLE_ID_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  velocity_cache_array_if.slave           mu,
  output logic [NUM_CELLS-1:0][CNT_W-1:0] cell_particle_count_o,
  output logic [NUM_CELLS-1:0]            overflow_o,
  output logic                            dst_error_o,
  output logic                            active_bank_o
);
  localparam int VW = 3 * DATA_WIDTH;

  logic                     wrEn;
  logic                     rdEn;
  logic [CELL_ID_WIDTH-1:0] dstX;
  logic [CELL_ID_WIDTH-1:0] dstY;
  logic [CELL_ID_WIDTH-1:0] dstZ;
  logic                     dstInRange;

  logic activeBank_q;
  logic dstError_q;
  logic valid_q;

  logic [NUM_CELLS-1:0][VW-1:0]    cellData;
  logic [NUM_CELLS-1:0][CNT_W-1:0] cellCount;
  logic [NUM_CELLS-1:0]            cellOverflow;

  assign wrEn = mu.Motion_Update_enable && mu.MU_wr_data_valid;
  assign rdEn = mu.Motion_Update_enable && mu.MU_rden;

  // Destination fields are 1-based; zero or beyond the grid edge is an error.
  assign dstX = mu.MU_dst_cell[3*CELL_ID_WIDTH-1:2*CELL_ID_WIDTH];
  assign dstY = mu.MU_dst_cell[2*CELL_ID_WIDTH-1:CELL_ID_WIDTH];
  assign dstZ = mu.MU_dst_cell[CELL_ID_WIDTH-1:0];
  assign dstInRange = (dstX != '0) && (int'(dstX) <= CELLS_X) &&
                      (dstY != '0) && (int'(dstY) <= CELLS_Y) &&
                      (dstZ != '0) && (int'(dstZ) <= CELLS_Z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      activeBank_q <= 1'b0;
      dstError_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      if (mu.MU_swap) activeBank_q <= ~activeBank_q;
      if (wrEn && !dstInRange) dstError_q <= 1'b1;
      valid_q <= rdEn;
    end
  end

  for (genvar gx = 0; gx < CELLS_X; gx++) begin : g_x
    for (genvar gy = 0; gy < CELLS_Y; gy++) begin : g_y
      for (genvar gz = 0; gz < CELLS_Z; gz++) begin : g_z
        localparam int C = gx * CELLS_Y * CELLS_Z + gy * CELLS_Z + gz;

        logic [VW-1:0]    mem [2][NUM_PARTICLE_PER_CELL];
        logic [CNT_W-1:0] wrPtr_q;
        logic [CNT_W-1:0] rdCount_q;
        logic             overflow_q;
        logic [VW-1:0]    dout_q;
        logic             hit;
        logic             full;
        logic             wrAcc;

        assign hit   = wrEn && dstInRange &&
                       (dstX == CELL_ID_WIDTH'(gx + 1)) &&
                       (dstY == CELL_ID_WIDTH'(gy + 1)) &&
                       (dstZ == CELL_ID_WIDTH'(gz + 1));
        assign full  = (wrPtr_q == CNT_W'(NUM_PARTICLE_PER_CELL));
        assign wrAcc = hit && !full;

        always_ff @(posedge clk) begin
          if (wrAcc) mem[~activeBank_q][wrPtr_q[PARTICLE_ID_WIDTH-1:0]] <= mu.MU_wr_data;
        end

        // A write in the swap cycle is already in the bank that becomes active, so count it.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            wrPtr_q    <= '0;
            rdCount_q  <= '0;
            overflow_q <= 1'b0;
            dout_q     <= '0;
          end else begin
            if (mu.MU_swap) begin
              rdCount_q <= wrPtr_q + CNT_W'(wrAcc);
              wrPtr_q   <= '0;
            end else if (wrAcc) begin
              wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (hit && full) overflow_q <= 1'b1;
            if (rdEn) begin
              dout_q <= ({1'b0, mu.MU_rd_addr} < rdCount_q) ?
                        mem[activeBank_q][mu.MU_rd_addr] : '0;
            end
          end
        end

        assign cellData[C]     = dout_q;
        assign cellCount[C]    = rdCount_q;
        assign cellOverflow[C] = overflow_q;
      end
    end
  end

  assign mu.velocity_data_out   = cellData;
  assign mu.velocity_data_valid = valid_q;
  assign cell_particle_count_o  = cellCount;
  assign overflow_o             = cellOverflow;
  assign dst_error_o            = dstError_q;
  assign active_bank_o          = activeBank_q;
endmodule

// File: tb/tb_velocity_cache_array.sv
// Directed scoreboard bench for velocity_cache_array: reads push expected per-cell vectors,
// a negedge monitor pops and compares them whenever the DUT raises valid.
module tb_velocity_cache_array;
  localparam int NC  = 125;
  localparam int DW  = 32;
  localparam int CW  = 8;

  typedef logic [NC-1:0][3*DW-1:0] cellVec_t;
  typedef logic [NC-1:0][CW-1:0]   cntVec_t;

  logic clk;
  logic rst;
  cntVec_t       cellCount;
  logic [NC-1:0] overflow;
  logic          dstError;
  logic          activeBank;

  int compCount = 0;
  int failCount = 0;
  cellVec_t expQ[$];

  velocity_cache_array_if #(
    .NUM_CELLS(NC), .DATA_WIDTH(DW), .CELL_ID_WIDTH(3), .PARTICLE_ID_WIDTH(7)
  ) mu ();

  velocity_cache_array dut (
    .clk                   (clk),
    .rst                   (rst),
    .mu                    (mu),
    .cell_particle_count_o (cellCount),
    .overflow_o            (overflow),
    .dst_error_o           (dstError),
    .active_bank_o         (activeBank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] dst(input int x, input int y, input int z);
    return {3'(x), 3'(y), 3'(z)};
  endfunction

  function automatic logic [95:0] vel(input logic [31:0] z, input logic [31:0] y, input logic [31:0] x);
    return {z, y, x};
  endfunction

  function automatic logic [1023:0] cntVec(input int c0, input int v0, input int c1, input int v1);
    cntVec_t v;
    v = '0;
    if (c0 >= 0) v[c0] = CW'(v0);
    if (c1 >= 0) v[c1] = CW'(v1);
    return 1024'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [1023:0] actual, input logic [1023:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    mu.Motion_Update_enable = 1'b0;
    mu.MU_rd_addr           = '0;
    mu.MU_rden              = 1'b0;
    mu.MU_wr_data           = '0;
    mu.MU_dst_cell          = '0;
    mu.MU_wr_data_valid     = 1'b0;
    mu.MU_swap              = 1'b0;
  endtask

  task automatic applyStimulus(input logic en, input logic rden, input logic [6:0] addr,
                               input logic wrv, input logic [8:0] dcell, input logic [95:0] data,
                               input logic swap);
    mu.Motion_Update_enable = en;
    mu.MU_rden              = rden;
    mu.MU_rd_addr           = addr;
    mu.MU_wr_data_valid     = wrv;
    mu.MU_dst_cell          = dcell;
    mu.MU_wr_data           = data;
    mu.MU_swap              = swap;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic doWrite(input logic [8:0] dcell, input logic [95:0] data);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, dcell, data, 1'b0);
  endtask

  task automatic doSwap();
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 9'd0, 96'd0, 1'b1);
  endtask

  task automatic doRead(input logic [6:0] addr, input cellVec_t expected);
    expQ.push_back(expected);
    applyStimulus(1'b1, 1'b1, addr, 1'b0, 9'd0, 96'd0, 1'b0);
  endtask

  // Scoreboard monitor: every valid must match the oldest outstanding expected vector.
  always @(negedge clk) begin
    cellVec_t expVec;
    if (!rst && mu.velocity_data_valid) begin
      compCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpectedValid: got valid=1 expected valid=0");
      end else begin
        expVec = expQ.pop_front();
        if (mu.velocity_data_out !== expVec) begin
          failCount++;
          for (int c = 0; c < NC; c++) begin
            if (mu.velocity_data_out[c] !== expVec[c]) begin
              $display("[TB] FAIL readData cell %0d: got %0h expected %0h",
                       c, mu.velocity_data_out[c], expVec[c]);
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    cellVec_t      e;
    logic [1023:0] ov;
    logic [95:0]   p1;
    logic [95:0]   p2;

    p1 = vel(32'h11, 32'h22, 32'h33);
    p2 = vel(32'h44, 32'h55, 32'h66);
    ov = '0;
    ov[38] = 1'b1;

    idleInputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetActiveBank", 1024'(activeBank), 1024'(0));
    checkOutput("resetValid", 1024'(mu.velocity_data_valid), 1024'(0));
    checkOutput("resetDataOut", 1024'(mu.velocity_data_out[10:0]), 1024'(0));
    checkOutput("resetCounts", 1024'(cellCount), cntVec(-1, 0, -1, 0));
    checkOutput("resetFlags", 1024'({overflow, dstError}), 1024'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Empty grid reads back zero everywhere.
    doRead(7'd0, '0);

    // One particle in each corner cell, then swap.
    doWrite(dst(1, 1, 1), vel(32'h3, 32'h2, 32'h1));
    doWrite(dst(5, 5, 5), vel(32'hA, 32'hB, 32'hC));
    doSwap();
    checkOutput("swap1ActiveBank", 1024'(activeBank), 1024'(1));
    checkOutput("swap1Counts", 1024'(cellCount), cntVec(0, 1, 124, 1));
    e = '0;
    e[0]   = vel(32'h3, 32'h2, 32'h1);
    e[124] = vel(32'hA, 32'hB, 32'hC);
    doRead(7'd0, e);
    doRead(7'd1, '0);

    // Fill cell (2,3,4) = idx 38 past capacity.
    for (int i = 0; i < 129; i++) doWrite(dst(2, 3, 4), vel(32'h38, 32'(i), 32'(i) + 32'h100));
    checkOutput("overflowBeforeSwap", 1024'(overflow), ov);
    doSwap();
    checkOutput("swap2ActiveBank", 1024'(activeBank), 1024'(0));
    checkOutput("swap2Counts", 1024'(cellCount), cntVec(38, 128, -1, 0));
    checkOutput("swap2Overflow", 1024'(overflow), ov);
    checkOutput("swap2DstError", 1024'(dstError), 1024'(0));
    e = '0;
    e[38] = vel(32'h38, 32'd127, 32'd127 + 32'h100);
    doRead(7'd127, e);
    e[38] = vel(32'h38, 32'd0, 32'h100);
    doRead(7'd0, e);

    // Out-of-range destinations.
    doWrite(dst(0, 1, 1), vel(32'hDEAD, 32'hDEAD, 32'hDEAD));
    doWrite(dst(6, 1, 1), vel(32'hBEEF, 32'hBEEF, 32'hBEEF));
    checkOutput("dstError", 1024'(dstError), 1024'(1));
    doSwap();
    checkOutput("swap3Counts", 1024'(cellCount), cntVec(-1, 0, -1, 0));
    checkOutput("swap3ActiveBank", 1024'(activeBank), 1024'(1));
    checkOutput("overflowSticky", 1024'(overflow), ov);
    doRead(7'd0, '0);

    // Write + swap + read in one cycle.
    doWrite(dst(1, 1, 1), p1);
    doSwap();
    checkOutput("swap4Counts", 1024'(cellCount), cntVec(0, 1, -1, 0));
    e = '0;
    e[0] = p1;
    expQ.push_back(e);
    applyStimulus(1'b1, 1'b1, 7'd0, 1'b1, dst(1, 1, 1), p2, 1'b1);
    checkOutput("swap5ActiveBank", 1024'(activeBank), 1024'(1));
    checkOutput("swap5Counts", 1024'(cellCount), cntVec(0, 1, -1, 0));
    e[0] = p2;
    doRead(7'd0, e);

    // Strobes with enable low are ignored; swap is not.
    applyStimulus(1'b0, 1'b1, 7'd0, 1'b1, dst(1, 1, 1), p1, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'd0, 1'b1, dst(0, 0, 0), p1, 1'b0);
    checkOutput("disabledCounts", 1024'(cellCount), cntVec(0, 1, -1, 0));
    checkOutput("disabledOverflow", 1024'(overflow), ov);
    doSwap();
    checkOutput("disabledSwapCounts", 1024'(cellCount), cntVec(-1, 0, -1, 0));
    checkOutput("disabledSwapActiveBank", 1024'(activeBank), 1024'(0));

    // Reset while a read result is on the output.
    mu.Motion_Update_enable = 1'b1;
    mu.MU_rden              = 1'b1;
    @(posedge clk);
    #1;
    idleInputs();
    rst = 1'b1;
    #1;
    checkOutput("midReadResetValid", 1024'(mu.velocity_data_valid), 1024'(0));
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReadResetFlags", 1024'({overflow, dstError, activeBank}), 1024'(0));
    checkOutput("midReadResetDataOut", 1024'(mu.velocity_data_out[10:0]), 1024'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pendingReads", 1024'(expQ.size()), 1024'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end
endmodule

// File: doc/velocity_cache_array.md
Name: velocity_cache_array

Overview:
- Parametrised 3-D grid of per-cell velocity caches for the MD core; grid dimensions are set by CELLS_X/Y/Z and built with generate loops.
- Each cell holds a ping-pong pair of banks:
  - Motion Update reads old velocities from the active bank.
  - Updated velocities go into the shadow bank of the destination cell, so particles can migrate between cells.
- A swap command exchanges the banks at the iteration boundary.
- Adds per-cell fill counters, read masking past the fill count, and per-cell overflow detection.

Parameters:
- CELLS_X, 5, cells along x
- CELLS_Y, 5, cells along y
- CELLS_Z, 5, cells along z
- DATA_WIDTH, 32, width of one velocity component
- CELL_ID_WIDTH, 3, width of one cell coordinate (1-based)
- NUM_PARTICLE_PER_CELL, 128, depth of each bank
- PARTICLE_ID_WIDTH, 7, particle address width
- Derived, not overridable: NUM_CELLS = CELLS_X*CELLS_Y*CELLS_Z; CNT_W = PARTICLE_ID_WIDTH+1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Motion_Update_enable  in  1  gates all reads and writes
- MU_rd_addr  in  PARTICLE_ID_WIDTH  read address, broadcast to all cells
- MU_rden  in  1  read strobe
- MU_wr_data  in  3*DATA_WIDTH  updated velocity {z,y,x}
- MU_dst_cell  in  3*CELL_ID_WIDTH  destination cell {x,y,z}, each field 1-based
- MU_wr_data_valid  in  1  write strobe
- MU_swap  in  1  one-cycle bank-swap pulse
- velocity_data_out  out  NUM_CELLS x 3*DATA_WIDTH  per-cell read data
- velocity_data_valid  out  1  read data valid
- cell_particle_count  out  NUM_CELLS x CNT_W  per-cell active-bank fill count
- overflow  out  NUM_CELLS  sticky per-cell overflow flag
- dst_error  out  1  sticky flag: write to an out-of-range cell
- active_bank  out  1  index of the bank currently being read

Behaviour:
- Reset (async, active-high). The following clear to 0:
  - active_bank, all wr_ptr, all rd_count, velocity_data_out, velocity_data_valid, overflow, dst_error.
  - RAM contents are not reset.
- Cell decode:
  - idx = (x-1)*CELLS_Y*CELLS_Z + (y-1)*CELLS_Z + (z-1).
  - Any field equal to 0 or greater than its dimension makes the destination out of range.
- Write (Motion_Update_enable & MU_wr_data_valid):
  - In range and wr_ptr[idx] < NUM_PARTICLE_PER_CELL: write MU_wr_data to bank ~active_bank at wr_ptr[idx]; wr_ptr[idx]++.
  - In range and wr_ptr[idx] == NUM_PARTICLE_PER_CELL: drop the write; set overflow[idx]; wr_ptr unchanged.
  - Out of range: drop the write; set dst_error.
- Read (Motion_Update_enable & MU_rden):
  - Every cell reads MU_rd_addr from bank active_bank.
  - velocity_data_out and velocity_data_valid update exactly 1 cycle later.
  - Cell c outputs 0 when MU_rd_addr >= rd_count[c].
  - velocity_data_valid pulses for 1 cycle per accepted read.
  - With no read, velocity_data_out holds its value and velocity_data_valid = 0.
- Strobes with Motion_Update_enable = 0 are ignored entirely: no writes, no flags, no valid.
- Swap (MU_swap, accepted regardless of enable):
  - active_bank toggles.
  - rd_count[c] <= wr_ptr[c] plus that cycle's accepted write to c, if any.
  - wr_ptr[c] <= 0.
- Same-cycle write and swap: the write lands in the pre-swap shadow bank, which becomes the new active bank, and is counted in the new rd_count.
- Same-cycle read and swap: the read uses the pre-swap active bank; data is returned next cycle unchanged.
- Back-to-back reads: one per cycle, fully pipelined.
- Read and write in the same cycle never touch the same bank, so there is no hazard.
- cell_particle_count = rd_count, registered.
- overflow and dst_error clear only on rst; swap does not clear them.
- Reset mid-operation: the in-flight read is discarded (valid = 0); counters return to 0.

Test Plan:
- Reset, then read addr 0 with enable=1 -> next cycle valid=1 and all 125 cells output 0 (rd_count = 0).
- Write 0x3/0x2/0x1 to cell (1,1,1), then 0xA/0xB/0xC to cell (5,5,5), then swap -> active_bank=1, count[0]=1, count[124]=1. Read addr 0 -> cell0 = {3,2,1}, cell124 = {A,B,C}, others 0, 1 cycle latency.
- Write 129 particles to cell (2,3,4) (idx 38), then swap -> count[38]=128, overflow[38]=1, all other overflow bits 0. Reading addr 127 returns the 128th write.
- Write to dst (0,1,1), then (6,1,1) -> dst_error=1, all wr_ptr remain 0, no RAM change.
- Issue a write to cell (1,1,1) together with swap, and a read together with swap:
  - The written particle appears at count[0]=1 after the swap.
  - The read returns pre-swap bank data.
- Drive MU_rden and MU_wr_data_valid with enable=0 -> no valid pulse, counts unchanged. Assert rst mid-read -> valid=0 immediately.
